// File: rtl/pcileech_tlp_pkg.sv
// Shared types for the parametrised TLP packer: 66-bit dual-dword entry layout
// and the write-side state encoding.
package pcileech_tlp_pkg;

  localparam int unsigned TLP_QW_W     = 66;
  localparam int unsigned QW_LAST_BIT  = 64;
  localparam int unsigned QW_KEEP2_BIT = 65;

  typedef struct packed {
    logic        keep2;
    logic        last;
    logic [31:0] dw2;
    logic [31:0] dw1;
  } tlp_qw_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    DISCARD = 2'd2
  } wr_state_t;

endpackage

// File: rtl/pcileech_tlp_slot_ring.sv
// Ring of NUM_SLOTS TLP slots: entry writes into the slot at wr_ptr, commit and
// pop strobes move the pointers, occupancy tracks committed slots.
module pcileech_tlp_slot_ring
  import pcileech_tlp_pkg::*;
#(
  parameter int unsigned NUM_QW    = 18,
  parameter int unsigned NUM_SLOTS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_clear,
  input  logic                           i_wr_en,
  input  logic [$clog2(NUM_QW+1)-1:0]    i_wr_idx,
  input  logic [TLP_QW_W-1:0]            i_wr_qw,
  input  logic                           i_commit,
  input  logic                           i_pop,
  output logic [TLP_QW_W*NUM_QW-1:0]     o_rd_slot,
  output logic [$clog2(NUM_SLOTS):0]     o_occupancy,
  output logic [$clog2(NUM_SLOTS):0]     o_occ_next
);

  localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned OCC_W = $clog2(NUM_SLOTS) + 1;
  localparam int unsigned IDX_W = $clog2(NUM_QW + 1);

  logic [NUM_SLOTS-1:0][NUM_QW-1:0][TLP_QW_W-1:0] r_slots;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (NUM_SLOTS == 1) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    w_occ_next = r_occ;
    case ({i_commit, i_pop})
      2'b10:   w_occ_next = r_occ + 1'b1;
      2'b01:   w_occ_next = r_occ - 1'b1;
      default: w_occ_next = r_occ;
    endcase
  end

  always_comb begin
    o_rd_slot = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (PTR_W'(s) == r_rd_ptr) o_rd_slot = r_slots[s];
    end
  end

  // Clear and entry write may hit the same slot on one edge; the entry write
  // is issued later so it takes precedence over the clear for that entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slots  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (PTR_W'(s) == r_wr_ptr) begin
          if (i_clear) r_slots[s] <= '0;
          if (i_wr_en) begin
            for (int unsigned q = 0; q < NUM_QW; q++) begin
              if (IDX_W'(q) == i_wr_idx) r_slots[s][q] <= i_wr_qw;
            end
          end
        end
      end
      if (i_commit) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)    r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_occ <= w_occ_next;
    end
  end

  assign o_occupancy = r_occ;
  assign o_occ_next  = w_occ_next;

endmodule

// File: rtl/pcileech_tlp_packer.sv
// Packs a 64-bit AXI-style TLP stream into one wide word per TLP, buffering
// complete TLPs in a slot ring and dropping oversize ones.
module pcileech_tlp_packer
  import pcileech_tlp_pkg::*;
#(
  parameter int unsigned NUM_QW     = 18,
  parameter int unsigned NUM_SLOTS  = 2,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [63:0]                rx_data,
  input  logic [7:0]                 rx_keep,
  input  logic                       rx_last,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [TLP_QW_W*NUM_QW-1:0] tlp_data,
  output logic                       tlp_valid,
  output logic                       tlp_has_data,
  input  logic                       tlp_req_data,
  output logic [DROP_CNT_W-1:0]      stat_drop_cnt,
  output logic [$clog2(NUM_SLOTS):0] stat_occupancy
);

  localparam int unsigned IDX_W = $clog2(NUM_QW + 1);
  localparam int unsigned OCC_W = $clog2(NUM_SLOTS) + 1;

  wr_state_t r_state, w_state_next;
  logic [IDX_W-1:0] r_wr_qw, w_wr_qw_next, w_wr_idx;
  logic w_acc, w_clear, w_wr_en, w_commit, w_drop, w_pop;
  tlp_qw_t w_beat;
  logic [OCC_W-1:0] w_occ, w_occ_next;
  logic [TLP_QW_W*NUM_QW-1:0] w_rd_slot;
  logic r_rx_ready, r_tlp_valid;
  logic [TLP_QW_W*NUM_QW-1:0] r_tlp_data;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic w_unused_keep;

  assign w_acc  = rx_valid & r_rx_ready;
  assign w_pop  = tlp_req_data & (w_occ != '0);
  assign w_beat = {rx_keep[4], rx_last, rx_data};
  assign w_unused_keep = ^{rx_keep[7:5], rx_keep[3:0]};

  pcileech_tlp_slot_ring #(
    .NUM_QW   (NUM_QW),
    .NUM_SLOTS(NUM_SLOTS)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_wr_idx),
    .i_wr_qw    (w_beat),
    .i_commit   (w_commit),
    .i_pop      (w_pop),
    .o_rd_slot  (w_rd_slot),
    .o_occupancy(w_occ),
    .o_occ_next (w_occ_next)
  );

  // Overflow is decided when a non-last beat fills the final entry, so a TLP of
  // exactly NUM_QW beats commits while one beat more is discarded.
  always_comb begin
    w_state_next = r_state;
    w_wr_qw_next = r_wr_qw;
    w_wr_idx     = r_wr_qw;
    w_clear      = 1'b0;
    w_wr_en      = 1'b0;
    w_commit     = 1'b0;
    w_drop       = 1'b0;
    if (w_acc) begin
      unique case (r_state)
        IDLE: begin
          w_clear      = 1'b1;
          w_wr_en      = 1'b1;
          w_wr_idx     = '0;
          w_wr_qw_next = IDX_W'(1);
          if (rx_last) begin
            w_commit = 1'b1;
          end else if (NUM_QW == 1) begin
            w_drop       = 1'b1;
            w_state_next = DISCARD;
          end else begin
            w_state_next = FILL;
          end
        end
        FILL: begin
          w_wr_en      = 1'b1;
          w_wr_qw_next = r_wr_qw + 1'b1;
          if (rx_last) begin
            w_commit     = 1'b1;
            w_state_next = IDLE;
          end else if (w_wr_qw_next == IDX_W'(NUM_QW)) begin
            w_drop       = 1'b1;
            w_state_next = DISCARD;
          end
        end
        DISCARD: begin
          if (rx_last) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_qw     <= '0;
      r_rx_ready  <= 1'b0;
      r_tlp_valid <= 1'b0;
      r_tlp_data  <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_wr_qw     <= w_wr_qw_next;
      r_rx_ready  <= (w_occ_next != OCC_W'(NUM_SLOTS)) || (w_state_next == DISCARD);
      r_tlp_valid <= w_pop;
      if (w_pop) r_tlp_data <= w_rd_slot;
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign rx_ready       = r_rx_ready;
  assign tlp_data       = r_tlp_data;
  assign tlp_valid      = r_tlp_valid;
  assign tlp_has_data   = (w_occ != '0);
  assign stat_drop_cnt  = r_drop_cnt;
  assign stat_occupancy = w_occ;

endmodule

// File: tb/tb_pcileech_tlp_packer.sv
// Self-checking bench for pcileech_tlp_packer: default instance plus a small
// NUM_QW=2 / NUM_SLOTS=1 instance, against a queue-based TLP model.
module tb_pcileech_tlp_packer;
  import pcileech_tlp_pkg::*;

  localparam int unsigned A_QW = 18, A_SLOTS = 2, A_DW = 16;
  localparam int unsigned B_QW = 2,  B_SLOTS = 1, B_DW = 2;
  localparam int unsigned WIDE = 66 * A_QW;
  localparam int BUDGET = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [63:0] rx_data;
  logic [7:0]  rx_keep;
  logic rx_last, rx_valid, req;
  int sel;

  logic a_valid_in, b_valid_in, a_req, b_req;
  assign a_valid_in = rx_valid && (sel == 0);
  assign b_valid_in = rx_valid && (sel == 1);
  assign a_req      = req && (sel == 0);
  assign b_req      = req && (sel == 1);

  logic a_ready, a_tlp_valid, a_has;
  logic [66*A_QW-1:0] a_tlp_data;
  logic [A_DW-1:0] a_drop;
  logic [$clog2(A_SLOTS):0] a_occ;
  logic b_ready, b_tlp_valid, b_has;
  logic [66*B_QW-1:0] b_tlp_data;
  logic [B_DW-1:0] b_drop;
  logic [$clog2(B_SLOTS):0] b_occ;

  pcileech_tlp_packer #(.NUM_QW(A_QW), .NUM_SLOTS(A_SLOTS), .DROP_CNT_W(A_DW)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_keep(rx_keep), .rx_last(rx_last),
    .rx_valid(a_valid_in), .rx_ready(a_ready), .tlp_data(a_tlp_data), .tlp_valid(a_tlp_valid),
    .tlp_has_data(a_has), .tlp_req_data(a_req), .stat_drop_cnt(a_drop), .stat_occupancy(a_occ));

  pcileech_tlp_packer #(.NUM_QW(B_QW), .NUM_SLOTS(B_SLOTS), .DROP_CNT_W(B_DW)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_keep(rx_keep), .rx_last(rx_last),
    .rx_valid(b_valid_in), .rx_ready(b_ready), .tlp_data(b_tlp_data), .tlp_valid(b_tlp_valid),
    .tlp_has_data(b_has), .tlp_req_data(b_req), .stat_drop_cnt(b_drop), .stat_occupancy(b_occ));

  logic c_ready, c_valid, c_has;
  logic [WIDE-1:0] c_data;
  int c_drop, c_occ;
  always_comb begin
    if (sel == 0) begin
      c_ready = a_ready; c_valid = a_tlp_valid; c_has = a_has; c_data = a_tlp_data;
      c_drop = int'(a_drop); c_occ = int'(a_occ);
    end else begin
      c_ready = b_ready; c_valid = b_tlp_valid; c_has = b_has; c_data = WIDE'(b_tlp_data);
      c_drop = int'(b_drop); c_occ = int'(b_occ);
    end
  end

  int checks = 0;
  int errors = 0;

  logic [WIDE-1:0] exp_a[$];
  logic [WIDE-1:0] exp_b[$];
  int exp_drop[2];

  logic [63:0] pk_data[32];
  logic [7:0]  pk_keep_last;
  int pk_len;

  task automatic set_sel(input int s);
    sel = s;
    #1;
  endtask

  function automatic int cur_qw();
    return (sel == 0) ? int'(A_QW) : int'(B_QW);
  endfunction

  function automatic int q_size();
    return (sel == 0) ? exp_a.size() : exp_b.size();
  endfunction

  function automatic logic [WIDE-1:0] expected_word();
    logic [WIDE-1:0] w;
    logic [65:0] e;
    w = '0;
    for (int i = 0; i < pk_len && i < cur_qw(); i++) begin
      e[63:0]          = pk_data[i];
      e[QW_LAST_BIT]   = (i == pk_len - 1);
      e[QW_KEEP2_BIT]  = (i == pk_len - 1) ? pk_keep_last[4] : 1'b1;
      w[66*i +: 66]    = e;
    end
    return w;
  endfunction

  function automatic int first_diff(input logic [WIDE-1:0] x, input logic [WIDE-1:0] y);
    for (int i = 0; i < int'(A_QW); i++) if (x[66*i +: 66] !== y[66*i +: 66]) return i;
    return 0;
  endfunction

  task automatic gen_pkt(input int n);
    pk_len = n;
    for (int i = 0; i < n; i++) pk_data[i] = {$urandom, $urandom};
    pk_keep_last = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h0F;
  endtask

  task automatic model_accept();
    int maxd;
    maxd = (sel == 0) ? 65535 : 3;
    if (pk_len > cur_qw()) begin
      if (exp_drop[sel] < maxd) exp_drop[sel]++;
    end else if (sel == 0) begin
      exp_a.push_back(expected_word());
    end else begin
      exp_b.push_back(expected_word());
    end
  endtask

  task automatic timeout_abort(input string name);
    errors++;
    $display("FAIL %s: rx_ready never asserted within %0d cycles", name, BUDGET);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  endtask

  // Drives beats from a negedge; returns at the negedge after the accepting edge.
  task automatic send_pkt(input int nbeats, input bit req_on_last);
    int n;
    if (nbeats == pk_len) model_accept();
    for (int i = 0; i < nbeats; i++) begin
      rx_data  = pk_data[i];
      rx_last  = (i == pk_len - 1);
      rx_keep  = rx_last ? pk_keep_last : 8'hFF;
      rx_valid = 1'b1;
      if (req_on_last && rx_last) req = 1'b1;
      n = 0;
      while (!c_ready) begin
        @(negedge clk);
        n++;
        if (n > BUDGET) timeout_abort("beat_accept");
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic pop_check(input string name);
    logic [WIDE-1:0] e;
    int k;
    checks++;
    if (q_size() == 0) begin
      errors++;
      $display("FAIL %s: model queue empty, nothing expected to pop", name);
      return;
    end
    e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
    checks++;
    if (c_has !== 1'b1) begin errors++; $display("FAIL %s has_data: got %b want 1", name, c_has); end
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (c_valid !== 1'b1) begin errors++; $display("FAIL %s valid: got %b want 1", name, c_valid); end
    checks++;
    if (c_data !== e) begin
      errors++; k = first_diff(c_data, e);
      $display("FAIL %s data: entry %0d got %h want %h", name, k, c_data[66*k +: 66], e[66*k +: 66]);
    end
    @(negedge clk);
    checks++;
    if (c_valid !== 1'b0) begin errors++; $display("FAIL %s pulse: valid got %b want 0", name, c_valid); end
    checks++;
    if (c_data !== e) begin errors++; $display("FAIL %s hold: tlp_data changed without pop", name); end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin errors++; $display("FAIL %s: got %0d want %0d", name, got, want); end
  endtask

  task automatic check_idle_outputs(input string name);
    check_int({name, "_ready"}, int'(c_ready), 0);
    check_int({name, "_valid"}, int'(c_valid), 0);
    check_int({name, "_has"}, int'(c_has), 0);
    check_int({name, "_drop"}, c_drop, 0);
    check_int({name, "_occ"}, c_occ, 0);
    checks++;
    if (c_data !== '0) begin errors++; $display("FAIL %s_data: got nonzero want 0", name); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      set_sel(s);
      check_idle_outputs(s == 0 ? "reset_a" : "reset_b");
    end
    set_sel(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      set_sel(s);
      check_int(s == 0 ? "ready_after_reset_a" : "ready_after_reset_b", int'(c_ready), 1);
    end
    set_sel(0);
  endtask

  task automatic test_mrd();
    logic [WIDE-1:0] d;
    set_sel(0);
    pk_len = 2;
    pk_data[0] = 64'h0000_0001_0000_0000;
    pk_data[1] = {$urandom, $urandom};
    pk_keep_last = 8'h0F;
    send_pkt(2, 1'b0);
    check_int("mrd_has_data", int'(c_has), 1);
    check_int("mrd_occ", c_occ, 1);
    pop_check("mrd_pop");
    d = c_data;
    check_int("mrd_e1_last", int'(d[66 + QW_LAST_BIT]), 1);
    check_int("mrd_e1_keep2", int'(d[66 + QW_KEEP2_BIT]), 0);
    check_int("mrd_e0_last", int'(d[QW_LAST_BIT]), 0);
    checks++;
    if (d[WIDE-1:132] !== '0) begin errors++; $display("FAIL mrd_upper: entries 2..17 nonzero want 0"); end
    check_int("mrd_occ_after", c_occ, 0);
  endtask

  task automatic test_fill();
    logic [WIDE-1:0] e;
    set_sel(0);
    for (int t = 0; t < 2; t++) begin gen_pkt(2); send_pkt(2, 1'b0); end
    check_int("fill_occ", c_occ, 2);
    check_int("fill_ready", int'(c_ready), 0);
    gen_pkt(2);
    rx_data = pk_data[0]; rx_keep = 8'hFF; rx_last = 1'b0; rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_int("fill_stall_ready", int'(c_ready), 0);
    end
    check_int("fill_stall_occ", c_occ, 2);
    e = exp_a.pop_front();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check_int("fill_pop_valid", int'(c_valid), 1);
    checks++;
    if (c_data !== e) begin errors++; $display("FAIL fill_pop_data: first TLP out of order"); end
    check_int("fill_ready_after_pop", int'(c_ready), 1);
    send_pkt(2, 1'b0);
    pop_check("fill_tlp2");
    pop_check("fill_tlp3");
  endtask

  task automatic test_oversize();
    set_sel(0);
    gen_pkt(19);
    send_pkt(19, 1'b0);
    check_int("over_has_data", int'(c_has), 0);
    check_int("over_drop", c_drop, exp_drop[0]);
    check_int("over_ready", int'(c_ready), 1);
    gen_pkt(2);
    send_pkt(2, 1'b0);
    pop_check("over_follow");
    gen_pkt(18);
    send_pkt(18, 1'b0);
    pop_check("over_exact18");
    check_int("over_e17_last", int'(c_data[66*17 + QW_LAST_BIT]), 1);
  endtask

  task automatic test_simultaneous();
    logic [WIDE-1:0] e;
    set_sel(0);
    gen_pkt(2); send_pkt(2, 1'b0);
    check_int("simul_occ_pre", c_occ, 1);
    gen_pkt(3); send_pkt(3, 1'b1);
    req = 1'b0;
    e = exp_a.pop_front();
    check_int("simul_valid", int'(c_valid), 1);
    checks++;
    if (c_data !== e) begin errors++; $display("FAIL simul_data: popped TLP is not the older one"); end
    check_int("simul_occ", c_occ, 1);
    @(negedge clk);
    pop_check("simul_tlp_b");
  endtask

  task automatic test_back_to_back();
    logic [WIDE-1:0] e;
    set_sel(0);
    for (int t = 0; t < 2; t++) begin gen_pkt($urandom_range(1, 18)); send_pkt(pk_len, 1'b0); end
    req = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      e = exp_a.pop_front();
      check_int("b2b_valid", int'(c_valid), 1);
      checks++;
      if (c_data !== e) begin errors++; $display("FAIL b2b_data: TLP %0d wrong", t); end
    end
    @(negedge clk);
    check_int("b2b_empty_req_ignored", int'(c_valid), 0);
    req = 1'b0;
    check_int("b2b_occ", c_occ, 0);
    gen_pkt(2); send_pkt(2, 1'b0);
    pop_check("b2b_no_queued_req");
  endtask

  task automatic test_reset_mid();
    set_sel(0);
    gen_pkt(6);
    send_pkt(3, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_a.delete(); exp_b.delete(); exp_drop[0] = 0; exp_drop[1] = 0;
    check_idle_outputs("rstmid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_int("rstmid_ready", int'(c_ready), 1);
    gen_pkt(2); send_pkt(2, 1'b0);
    pop_check("rstmid_fresh");
  endtask

  task automatic test_small();
    set_sel(1);
    for (int t = 0; t < 4; t++) begin
      gen_pkt(3); send_pkt(3, 1'b0);
      check_int("small_drop", c_drop, exp_drop[1]);
      check_int("small_has", int'(c_has), 0);
    end
    check_int("small_drop_sat", c_drop, 3);
    gen_pkt(2); send_pkt(2, 1'b0);
    check_int("small_ready_full", int'(c_ready), 0);
    @(negedge clk);
    check_int("small_ready_still", int'(c_ready), 0);
    pop_check("small_pop");
    check_int("small_ready_free", int'(c_ready), 1);
    gen_pkt(1); send_pkt(1, 1'b0);
    pop_check("small_single_beat");
    set_sel(0);
  endtask

  task automatic test_random();
    set_sel(0);
    for (int t = 0; t < 40; t++) begin
      if (exp_a.size() == int'(A_SLOTS)) pop_check("rand_pop_full");
      gen_pkt($urandom_range(1, 21));
      send_pkt(pk_len, 1'b0);
      check_int("rand_occ", c_occ, exp_a.size());
      if (exp_a.size() > 0 && $urandom_range(0, 1) == 1) pop_check("rand_pop");
    end
    while (exp_a.size() > 0) pop_check("rand_drain");
    check_int("rand_drop", c_drop, exp_drop[0]);
    check_int("rand_has_end", int'(c_has), 0);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_keep = '0; rx_last = 1'b0; rx_valid = 1'b0; req = 1'b0;
    sel = 0; exp_drop[0] = 0; exp_drop[1] = 0;
    test_reset();
    test_mrd();
    test_fill();
    test_oversize();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_small();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pcileech_tlp_packer.md
Name: pcileech_tlp_packer

Overview:
Parametrised successor to the fixed IfTlp16/64/128 packers. It takes one AXI-style 64-bit TLP stream (data/keep/last/valid/ready) and buffers complete TLPs in a ring of NUM_SLOTS slots. Each TLP leaves as one wide parallel word of NUM_QW 66-bit dual-dword entries on a has_data/req_data/valid handshake. It sits between the PCIe core RX path and the TLP/FIFO consumers, and one instance per width replaces the separate fixed-size packers.

Parameters:
NUM_QW, 18, dual-dword entries per output word (18 = 4 DW header + 32 DW data).
NUM_SLOTS, 2, buffered complete TLPs; power of two, ≥1.
DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
clk  in  1  single clock.
rst_n  in  1  reset; asynchronous assert, active-low.
rx_data  in  64  TLP beat; [31:0] = DW1, [63:32] = DW2.
rx_keep  in  8  byte enables; [3:0] always 0xF; [7:4] is 0x0 or 0xF.
rx_last  in  1  final beat of the TLP.
rx_valid  in  1  beat valid.
rx_ready  out  1  beat accepted when rx_valid & rx_ready.
tlp_data  out  66*NUM_QW  packed TLP; entry i = bits [66i+65:66i]: [31:0] DW1, [63:32] DW2, [64] LAST, [65] KEEP DW2.
tlp_valid  out  1  one-cycle pulse; tlp_data holds a TLP.
tlp_has_data  out  1  at least one complete TLP is buffered.
tlp_req_data  in  1  sink requests the next TLP.
stat_drop_cnt  out  DROP_CNT_W  oversize TLPs discarded; saturates.
stat_occupancy  out  $clog2(NUM_SLOTS)+1  committed slots.

Behaviour:
- Reset (rst_n low, async): all outputs and all slot contents go to 0. rx_ready = 0 while in reset and 1 from the first clock after deassertion. A partially written TLP is lost.
- Write side: states IDLE / FILL / DISCARD; write-beat index wr_qw has width $clog2(NUM_QW+1).
- IDLE, beat accepted: clear slot[wr_ptr] to zero, then store entry 0 as {rx_keep[4], rx_last, rx_data}, with wr_qw = 1.
  - If rx_last: commit. Otherwise go to FILL.
- FILL, beat accepted:
  - If wr_qw < NUM_QW: store the entry at index wr_qw and increment wr_qw.
  - If rx_last: commit and return to IDLE.
  - If wr_qw == NUM_QW and the beat is not last: slot abandoned (not committed), stat_drop_cnt += 1 saturating, go to DISCARD.
- DISCARD: accept and drop beats; rx_last returns to IDLE.
- A NUM_QW-beat TLP whose final beat has rx_last is legal and is not dropped.
- Commit: wr_ptr += 1 (wraps mod NUM_SLOTS), occupancy += 1.
  - tlp_has_data rises in the cycle after the edge that accepted the last beat.
- rx_ready = (occupancy != NUM_SLOTS) || state == DISCARD. Registered; updates the cycle after a commit or pop.
- Entries past the TLP's last beat read as 0; exactly one entry in the slot has LAST = 1.
- Read side: at an edge where tlp_req_data & tlp_has_data:
  - tlp_data <= slot[rd_ptr]; tlp_valid <= 1 for exactly one cycle.
  - rd_ptr wraps mod NUM_SLOTS; occupancy -= 1.
- Latency: request edge to valid = 1 cycle. Back-to-back requests yield one TLP per cycle while any are buffered.
- A request with tlp_has_data = 0 is ignored (no queuing).
- tlp_data holds its value until the next pop.
- Commit and pop on the same edge: occupancy unchanged, FIFO order preserved.
  - With occupancy == NUM_SLOTS, a pop frees the slot at that edge and rx_ready rises next cycle.
- NUM_SLOTS = 1: the ring degenerates to a single buffer with the same rules.

Decomposition:
- Package pcileech_tlp_pkg holds:
  - TLP_QW_W = 66, QW_LAST_BIT = 64, QW_KEEP2_BIT = 65;
  - typedef tlp_qw_t (packed struct keep2, last, dw2, dw1);
  - write-state enum {IDLE, FILL, DISCARD}.
- Sub-module pcileech_tlp_slot_ring owns the slot storage, pointers and occupancy, with commit/pop/clear strobes.
- The top level owns the write FSM and the output register.

Test Plan:
1. 3DW MRd: beat0 {DW2, DW1} = {0x0000_0001, 0x0000_0000}, keep 0xFF; beat1 keep 0x0F, last → has_data = 1 the cycle after beat1; req → valid pulse with entry1[64] = 1, entry1[65] = 0, entry0[64] = 0, entries 2..17 = 0; occupancy back to 0.
2. Fill: two 2-beat TLPs, no req → occupancy = 2, rx_ready = 0, third TLP stalls. One req → rx_ready = 1 next cycle, third TLP accepted. Order out is TLP1, TLP2, TLP3.
3. Oversize: 19-beat TLP with NUM_QW = 18 → no has_data, stat_drop_cnt = 1, rx_ready stays 1. A following 2-beat TLP is delivered intact. An exactly 18-beat TLP is delivered with entry17[64] = 1.
4. Simultaneous: occupancy = 1, req on the same edge the last beat of TLP B is accepted → valid with TLP A, occupancy stays 1, next req yields TLP B.
5. Reset mid-packet: rst_n low after 3 beats of a 6-beat TLP → all outputs 0. After release a fresh 2-beat TLP is delivered with no residue from the prior slot.
6. Params NUM_QW = 2, NUM_SLOTS = 1, DROP_CNT_W = 2: four 3-beat TLPs → stat_drop_cnt saturates at 3. A 2-beat TLP passes; rx_ready = 0 until it is popped.
